// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared defaults and pointer-width helper for the sync FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

  localparam int SYNC_FIFO_DATA_WIDTH = 8;
  localparam int SYNC_FIFO_DEPTH      = 8;

  function automatic int sync_fifo_ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module      : sync_fifo_mem
// Description : DEPTH x DATA_WIDTH register array, one synchronous write port
//               and one registered read port with a synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SYNC_FIFO_DATA_WIDTH,
  parameter int DEPTH      = SYNC_FIFO_DEPTH,
  parameter int ADDR_WIDTH = sync_fifo_ptr_width(SYNC_FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rd_clr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Storage is intentionally not reset; validity is tracked by the core.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_clr) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_core.sv
// ============================================================================
// Module      : sync_fifo_core
// Description : Single-clock FIFO with occupancy counter, full/empty flags and
//               a registered read port. Define SYNC_FIFO_ERR_FLAGS_EN to add
//               registered overflow/underflow pulse outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_core
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SYNC_FIFO_DATA_WIDTH,
  parameter int DEPTH      = SYNC_FIFO_DEPTH
) (
  input  logic                  clk_wr,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int c_ADDR_WIDTH = sync_fifo_ptr_width(DEPTH);
  localparam int c_CNT_WIDTH  = c_ADDR_WIDTH + 1;

  localparam logic [c_ADDR_WIDTH-1:0] c_PTR_ONE    = c_ADDR_WIDTH'(1);
  localparam logic [c_CNT_WIDTH-1:0]  c_CNT_ONE    = c_CNT_WIDTH'(1);
  localparam logic [c_CNT_WIDTH-1:0]  c_CNT_ZERO   = '0;
  localparam logic [c_CNT_WIDTH-1:0]  c_CNT_FULL   = c_CNT_WIDTH'(DEPTH);

  logic [c_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [c_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [c_CNT_WIDTH-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full   = (r_count == c_CNT_FULL);
  assign w_empty  = (r_count == c_CNT_ZERO);
  // Reset wins over any request presented in the same cycle.
  assign w_wr_acc = wr_en & ~w_full  & ~rst;
  assign w_rd_acc = rd_en & ~w_empty & ~rst;

  always_ff @(posedge clk_wr) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (c_ADDR_WIDTH)
  ) u_mem (
    .clk     (clk_wr),
    .rd_clr  (rst),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr),
    .wr_data (d_in),
    .rd_en   (w_rd_acc),
    .rd_addr (r_rd_ptr),
    .rd_data (d_out)
  );

  assign full  = w_full;
  assign empty = w_empty;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk_wr) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en & w_full;
      r_underflow <= rd_en & w_empty;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_core.sv
// ============================================================================
// Module      : tb_sync_fifo_core
// Description : Directed scoreboard bench for sync_fifo_core (optionally with
//               SYNC_FIFO_ERR_FLAGS_EN defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_core;

  localparam int c_DW    = 8;
  localparam int c_DEPTH = 8;

  logic            clk_wr = 1'b0;
  logic            rst    = 1'b1;
  logic            wr_en  = 1'b0;
  logic            rd_en  = 1'b0;
  logic [c_DW-1:0] d_in   = '0;
  logic [c_DW-1:0] d_out;
  logic            full;
  logic            empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic            overflow;
  logic            underflow;
`endif

  always #5 clk_wr = ~clk_wr;

  sync_fifo_core #(
    .DATA_WIDTH (c_DW),
    .DEPTH      (c_DEPTH)
  ) dut (
    .clk_wr    (clk_wr),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .d_in      (d_in),
    .d_out     (d_out),
    .full      (full),
    .empty     (empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [c_DW-1:0] exp_q [$];
  logic [c_DW-1:0] model_q [$];
  int              m_count  = 0;
  bit              exp_ovf  = 1'b0;
  bit              exp_unf  = 1'b0;
  logic [c_DW-1:0] last_exp = '0;
  bit              presented;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; the reference queue model updates at the edge.
  task automatic step(input bit wr, input bit rd, input logic [c_DW-1:0] din, input bit r = 1'b0);
    bit acc_wr;
    bit acc_rd;
    @(negedge clk_wr);
    rst   = r;
    wr_en = wr;
    rd_en = rd;
    d_in  = din;
    @(posedge clk_wr);
    if (r) begin
      model_q.delete();
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      acc_wr  = wr && (m_count < c_DEPTH);
      acc_rd  = rd && (m_count > 0);
      exp_ovf = wr && (m_count == c_DEPTH);
      exp_unf = rd && (m_count == 0);
      if (acc_rd) exp_q.push_back(model_q.pop_front());
      if (acc_wr) model_q.push_back(din);
    end
    m_count = model_q.size();
  endtask

  // Monitor: pops an expected word whenever the DUT accepts a read.
  always @(posedge clk_wr) begin
    presented = rd_en && !empty && !rst;
    #1;
    if (rst) begin
      last_exp = '0;
      check("rst_dout", 32'(d_out), 32'h0);
    end else if (presented) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", 32'(d_out), 32'(last_exp));
        miscompares++;
        $display("FAIL unexpected_read @%0t: got read with empty scoreboard, expected none", $time);
      end else begin
        last_exp = exp_q.pop_front();
        check("rd_data", 32'(d_out), 32'(last_exp));
      end
    end else begin
      check("dout_hold", 32'(d_out), 32'(last_exp));
    end
    check("empty", 32'(empty), 32'(m_count == 0));
    check("full", 32'(full), 32'(m_count == c_DEPTH));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
`endif
  end

  initial begin
    // Reset held for two cycles
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00);

    // Fill, then a write while full
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b1, 1'b0, 8'h20);
    step(1'b0, 1'b0, 8'h00);

    // Drain 0x10..0x17, then a read while empty
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Wrap-around
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00);

    // Simultaneous read/write at count=3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h50 + i));
    // Fill to full, then both asserted: read only, count 7
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    step(1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00);
    // Empty with both asserted: write only, count 1
    step(1'b1, 1'b1, 8'h88);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Reset mid-operation with a concurrent write
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b1, 1'b0, 8'h99, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_core.md
# sync_fifo_core

Single-clock, first-in first-out buffer for passing data words between a producer and a consumer on the same clock. Storage is a register array of DEPTH words with binary read and write pointers and an occupancy counter. full and empty flags provide backpressure, and d_out is a registered read port. It sits between streaming blocks wherever rate decoupling is needed without a clock-domain crossing.

## Interface
Parameters:
- DATA_WIDTH, 8: word width in bits; minimum 1.
- DEPTH, 8: number of entries; power of two, minimum 2.

Ports (one clock; reset is synchronous and active-high):
- clk_wr  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request; accepted only when full=0.
- rd_en  input  1  read request; accepted only when empty=0.
- d_in  input  DATA_WIDTH  write data, sampled on an accepted write.
- d_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when count==DEPTH.
- empty  output  1  high when count==0.

## Operation
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits.
  - count, $clog2(DEPTH)+1 bits, range 0..DEPTH.
  - mem[DEPTH], not reset.
- Accepted write (wr_en & ~full): mem[wr_ptr] <= d_in; wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Accepted read (rd_en & ~empty): d_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
- Rejected requests (write while full, read while empty) are dropped. They change no state, and d_out holds its value.
- count:
  - +1 on write-only.
  - −1 on read-only.
  - unchanged when both or neither are accepted.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both are accepted; count is unchanged.
  - Empty: only the write is accepted.
  - Full: only the read is accepted; the write is dropped.
- full and empty are decoded combinationally from count and are never both high.
- On reset: wr_ptr=0, rd_ptr=0, count=0, d_out=0, full=0, empty=1. Contents are discarded logically. Reset asserted mid-operation overrides any wr_en/rd_en in the same cycle.

## Timing
- Write-to-flag latency is 1 cycle: the edge that accepts a write updates count, so empty falls and full rises right after that edge.
- Read latency is 1 cycle: data appears on d_out after the accepting edge and holds until the next accepted read.
- First-word latency is 2 edges: the write edge, then the read edge, then d_out is valid.
- Sustained throughput is one write and one read per cycle.
- Inputs need only meet setup/hold to clk_wr. No combinational path exists from wr_en, rd_en or d_in to any output.

## Configuration
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds output overflow (1 bit), registered and high for exactly one cycle after an edge where wr_en=1 while full=1.
  - Adds output underflow (1 bit), with the same behaviour for rd_en=1 while empty=1.
  - Both reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Package sync_fifo_pkg holds:
  - default constants SYNC_FIFO_DATA_WIDTH=8 and SYNC_FIFO_DEPTH=8;
  - a function for pointer width, returning $clog2(DEPTH).
- One sub-module, sync_fifo_mem: a DEPTH x DATA_WIDTH register array with one synchronous write port and one registered read port (write enable, write address, read enable, read address). Pointer, count, flag and reset logic stay in sync_fifo_core.

## Test plan
- Reset: hold rst=1 for 2 cycles, then release -> empty=1, full=0, d_out=0.
- Fill: write 0x10, 0x11, …, 0x17 on 8 consecutive cycles -> empty=0 after the first edge, full=1 after the 8th edge; then write 0x20 while full -> contents unchanged, overflow pulses once (macro on).
- Drain: assert rd_en for 8 cycles -> d_out = 0x10..0x17 in order, empty=1 after the 8th read; a 9th read -> d_out stays 0x17, underflow pulses once (macro on).
- Wrap-around: write 5 words, read 5, write 6 words (0xA0..0xA5), read 6 -> output is 0xA0..0xA5 in order and count returns to 0.
- Simultaneous: with count=3, assert wr_en and rd_en for 4 cycles -> count stays 3 and order is preserved. When full with both asserted -> read proceeds, write dropped, count becomes 7. When empty with both asserted -> write only, count becomes 1.
- Reset mid-operation: with count=5, assert rst together with wr_en=1 -> next cycle count=0, empty=1, d_out=0, and the write is ignored.
